// File: rtl/imem_pkg.sv
// Shared constants and types for the fetch-stage instruction memory.
package imem_pkg;

  localparam logic [31:0] IMEM_BASE_DEFAULT  = 32'h0000_3000;
  localparam int unsigned IMEM_DEPTH_DEFAULT = 1024;

  // All-zero word doubles as the MIPS NOP (sll $0,$0,0).
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Bit positions inside the 2-bit fault vector.
  localparam int unsigned FAULT_MISALIGN = 0;
  localparam int unsigned FAULT_RANGE    = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } imem_state_e;

endpackage

// File: rtl/imem_addr_check.sv
// Byte-address decode for the instruction memory: word index plus
// misalignment and out-of-range flags. Purely combinational.
module imem_addr_check
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE_DEFAULT,
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_DEFAULT,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic [31:0]   addr_i,
  output logic [AW-1:0] idx_o,
  output logic          misalign_o,
  output logic          range_o
);

  // One extra bit so the byte limit cannot overflow for large depths.
  localparam logic [32:0] LimitBytes = 33'(DEPTH_WORDS) * 33'd4;

  logic [31:0] off;

  // Modulo subtraction: addresses below the base wrap to a huge offset and
  // therefore fall out of range without a separate lower-bound compare.
  assign off        = addr_i - BASE_ADDR;
  assign misalign_o = (off[1:0] != 2'b00);
  assign range_o    = ({1'b0, off} >= LimitBytes);
  assign idx_o      = off[AW+1:2];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory for the fetch stage: zero-fill after reset, handshaked
// program-load port, registered fetch with valid/fault reporting.
module instr_mem_ctrl
  import imem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE_DEFAULT,
  parameter int unsigned DEPTH_WORDS = IMEM_DEPTH_DEFAULT,
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic        clock,
  input  logic        reset,
  output logic        init_busy_o,
  input  logic        fetch_req_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_pc_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic [1:0]  instr_fault_o,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        load_err_o
);

  localparam logic [AW-1:0] LastIdx = AW'(DEPTH_WORDS - 1);

  imem_state_e   state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  logic [AW-1:0] fetch_idx, load_idx;
  logic          fetch_mis, fetch_rng, load_mis, load_rng;
  logic [1:0]    fetch_fault;
  logic          load_bad;

  logic          running, clearing;
  logic          fetch_acc, load_acc, rd_en;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   rd_q;

  logic          valid_q, nop_q, load_err_q;
  logic [1:0]    fault_q;

  imem_addr_check #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_fetch_check (
    .addr_i     (fetch_pc_i),
    .idx_o      (fetch_idx),
    .misalign_o (fetch_mis),
    .range_o    (fetch_rng)
  );

  imem_addr_check #(
    .BASE_ADDR   (BASE_ADDR),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_load_check (
    .addr_i     (load_addr_i),
    .idx_o      (load_idx),
    .misalign_o (load_mis),
    .range_o    (load_rng)
  );

  // Assemble the fetch fault vector from the decoder flags.
  always_comb begin
    fetch_fault                 = '0;
    fetch_fault[FAULT_MISALIGN] = fetch_mis;
    fetch_fault[FAULT_RANGE]    = fetch_rng;
  end

  assign load_bad = load_mis | load_rng;

  // FSM next state and handshake outputs; reset overrides everything.
  always_comb begin
    state_d       = state_q;
    clr_idx_d     = clr_idx_q;
    running       = 1'b0;
    clearing      = 1'b0;
    init_busy_o   = 1'b1;
    fetch_ready_o = 1'b0;
    load_ready_o  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_CLEAR: begin
          clearing  = 1'b1;
          clr_idx_d = clr_idx_q + AW'(1);
          if (clr_idx_q == LastIdx) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          running       = 1'b1;
          init_busy_o   = 1'b0;
          fetch_ready_o = 1'b1;
          load_ready_o  = 1'b1;
        end
        default: state_d = ST_CLEAR;
      endcase
    end
  end

  // FSM state register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign fetch_acc = fetch_req_i & running;
  assign load_acc  = load_valid_i & running;
  // Faulted fetches never touch the array.
  assign rd_en     = fetch_acc & ~(|fetch_fault);

  // Single write port: zero-fill during CLEAR, clean loads during RUN.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_idx_q;
    mem_wdata = INSTR_NOP;
    if (clearing) begin
      mem_we = 1'b1;
    end else if (load_acc && !load_bad) begin
      mem_we    = 1'b1;
      mem_waddr = load_idx;
      mem_wdata = load_data_i;
    end
  end

  // Memory array with a synchronous read-first port (no reset, RAM-friendly).
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    if (rd_en) begin
      rd_q <= mem_q[fetch_idx];
    end
  end

  // Fetch response and load-error registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      fault_q    <= '0;
      nop_q      <= 1'b1;
      load_err_q <= 1'b0;
    end else begin
      valid_q    <= fetch_acc;
      load_err_q <= load_acc & load_bad;
      if (fetch_acc) begin
        fault_q <= fetch_fault;
        nop_q   <= |fetch_fault;
      end
    end
  end

  // nop_q masks rd_q after reset and after faulted fetches, so rd_q need not
  // be cleared; reset also forces all response outputs quiet.
  assign instr_o       = (reset || nop_q) ? INSTR_NOP : rd_q;
  assign instr_valid_o = valid_q & ~reset;
  assign instr_fault_o = reset ? 2'b00 : fault_q;
  assign load_err_o    = load_err_q & ~reset;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Self-checking bench for instr_mem_ctrl: a scoreboard of expected fetch
// results checked by a monitor, plus per-scenario inline checks.
module tb_instr_mem_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        init_busy_o;
  logic        fetch_req_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] fetch_pc_i = '0;
  logic [31:0] instr_o;
  logic        instr_valid_o;
  logic [1:0]  instr_fault_o;
  logic        load_valid_i = 1'b0;
  logic        load_ready_o;
  logic [31:0] load_addr_i = '0;
  logic [31:0] load_data_i = '0;
  logic        load_err_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic        run_exp = 1'b0;
  logic [31:0] model [DEPTH];
  logic [33:0] exp_q [$];
  logic [33:0] mon_exp;

  instr_mem_ctrl #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .init_busy_o   (init_busy_o),
    .fetch_req_i   (fetch_req_i),
    .fetch_ready_o (fetch_ready_o),
    .fetch_pc_i    (fetch_pc_i),
    .instr_o       (instr_o),
    .instr_valid_o (instr_valid_o),
    .instr_fault_o (instr_fault_o),
    .load_valid_i  (load_valid_i),
    .load_ready_o  (load_ready_o),
    .load_addr_i   (load_addr_i),
    .load_data_i   (load_data_i),
    .load_err_o    (load_err_o)
  );

  always #5 clock = ~clock;

  // Expected {fault, instr} for a fetch against the current model contents.
  function automatic logic [33:0] exp_fetch(input logic [31:0] pc);
    logic [31:0] off;
    logic [1:0]  f;
    logic [31:0] w;
    off  = pc - BASE;
    f[0] = (off[1:0] != 2'b00);
    f[1] = (off >= 32'(DEPTH * 4));
    w    = (f != 2'b00) ? 32'h0 : model[off[11:2]];
    return {f, w};
  endfunction

  function automatic logic addr_faults(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
  endfunction

  // Scoreboard monitor: every valid result must match the oldest expectation.
  always @(negedge clock) begin
    if (instr_valid_o === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: instr_valid=1 instr=%h with no fetch outstanding",
                 instr_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({instr_fault_o, instr_o} !== mon_exp) begin
          n_bad++;
          $display("FAIL fetch_result: got fault=%b instr=%h, expected fault=%b instr=%h",
                   instr_fault_o, instr_o, mon_exp[33:32], mon_exp[31:0]);
        end
      end
    end
  end

  // One cycle of stimulus; called just after a rising edge, returns 1ns after the next.
  task automatic step(input logic fr, input logic [31:0] pc, input logic lv,
                      input logic [31:0] la, input logic [31:0] ld);
    fetch_req_i  = fr;
    fetch_pc_i   = pc;
    load_valid_i = lv;
    load_addr_i  = la;
    load_data_i  = ld;
    // Fetch expectation taken before the load updates the model: read-first.
    if (run_exp && fr) exp_q.push_back(exp_fetch(pc));
    if (run_exp && lv && !addr_faults(la)) model[la[11:2]] = ld;
    @(posedge clock);
    #1;
    fetch_req_i  = 1'b0;
    load_valid_i = 1'b0;
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clock);
    #1;
    reset        = 1'b1;
    fetch_req_i  = 1'b0;
    load_valid_i = 1'b0;
    run_exp      = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (init_busy_o !== 1'b1) begin
      n_bad++; $display("FAIL rst_init_busy: got %b want 1", init_busy_o);
    end
    n_cmp++;
    if ({fetch_ready_o, load_ready_o} !== 2'b00) begin
      n_bad++; $display("FAIL rst_ready: got %b want 00", {fetch_ready_o, load_ready_o});
    end
    n_cmp++;
    if ({instr_valid_o, instr_fault_o, load_err_o} !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_flags: got valid=%b fault=%b lerr=%b want 0/00/0",
               instr_valid_o, instr_fault_o, load_err_o);
    end
    n_cmp++;
    if (instr_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_instr: got %h want 00000000", instr_o);
    end
    reset = 1'b0;
    n = 0;
    while (init_busy_o === 1'b1 && n < 2000) begin
      n++;
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++; $display("FAIL fill_length: init_busy high %0d cycles, want %0d", n, DEPTH);
    end
    n_cmp++;
    if ({fetch_ready_o, load_ready_o} !== 2'b11) begin
      n_bad++; $display("FAIL run_ready: got %b want 11", {fetch_ready_o, load_ready_o});
    end
    run_exp = 1'b1;
    step(1'b1, 32'h3000, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h3FFC, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL reset_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_load_fetch();
    step(1'b0, 32'h0, 1'b1, 32'h3004, 32'h8C22_0004);
    step(1'b1, 32'h3004, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h8C22_0004 || instr_fault_o !== 2'b00) begin
      n_bad++;
      $display("FAIL load_fetch: got valid=%b instr=%h fault=%b want 1/8c220004/00",
               instr_valid_o, instr_o, instr_fault_o);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (instr_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL valid_pulse: got valid=%b want 0", instr_valid_o);
    end
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL load_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_collision();
    step(1'b0, 32'h0, 1'b1, 32'h3008, 32'h1111_1111);
    step(1'b1, 32'h3008, 1'b1, 32'h3008, 32'h2222_2222);
    n_cmp++;
    if (instr_o !== 32'h1111_1111) begin
      n_bad++; $display("FAIL read_first: got %h want 11111111", instr_o);
    end
    step(1'b1, 32'h3008, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (instr_o !== 32'h2222_2222) begin
      n_bad++; $display("FAIL refetch: got %h want 22222222", instr_o);
    end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL collision_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_faults();
    step(1'b0, 32'h0, 1'b1, 32'h3000, 32'hA5A5_A5A5);
    step(1'b1, 32'h3002, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (instr_fault_o !== 2'b01 || instr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL misalign: got fault=%b instr=%h want 01/00000000", instr_fault_o, instr_o);
    end
    step(1'b1, 32'h4000, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h2FFC, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0001, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (instr_fault_o !== 2'b11) begin
      n_bad++; $display("FAIL both_faults: got fault=%b want 11", instr_fault_o);
    end
    // 0x4000 aliases word 0 if the range check were ignored.
    step(1'b0, 32'h0, 1'b1, 32'h4000, 32'h5A5A_5A5A);
    n_cmp++;
    if (load_err_o !== 1'b1) begin
      n_bad++; $display("FAIL load_err_range: got %b want 1", load_err_o);
    end
    step(1'b0, 32'h0, 1'b1, 32'h3005, 32'h5A5A_5A5A);
    n_cmp++;
    if (load_err_o !== 1'b1) begin
      n_bad++; $display("FAIL load_err_misalign: got %b want 1", load_err_o);
    end
    step(1'b0, 32'h0, 1'b1, 32'h3FFC, 32'h0BAD_F00D);
    n_cmp++;
    if (load_err_o !== 1'b0) begin
      n_bad++; $display("FAIL load_err_clean: got %b want 0", load_err_o);
    end
    step(1'b1, 32'h3000, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h3004, 1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h3FFC, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL fault_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [31:0] la;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 32'h0, 1'b1, BASE + 32'(4 * i), $urandom());
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, BASE + 32'(4 * i), 1'b0, 32'h0, 32'h0);
    end
    for (int i = 0; i < 60; i++) begin
      a  = ($urandom_range(0, 5) == 0) ? $urandom() : BASE + 32'(4 * $urandom_range(0, 15));
      la = ($urandom_range(0, 5) == 0) ? $urandom() : BASE + 32'(4 * $urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), la, $urandom());
    end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL b2b_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_midfill_reset();
    int n;
    apply_reset(2);
    fetch_req_i = 1'b1;
    fetch_pc_i  = 32'h3000;
    repeat (500) @(posedge clock);
    #1;
    n_cmp++;
    if (init_busy_o !== 1'b1 || fetch_ready_o !== 1'b0) begin
      n_bad++;
      $display("FAIL midfill_busy: got busy=%b ready=%b want 1/0", init_busy_o, fetch_ready_o);
    end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n = 0;
    while (init_busy_o === 1'b1 && n < 2000) begin
      n++;
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++; $display("FAIL refill_length: init_busy high %0d cycles, want %0d", n, DEPTH);
    end
    // Request has been high all along; it is accepted only now, in the first RUN cycle.
    run_exp = 1'b1;
    step(1'b1, 32'h3000, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (instr_valid_o !== 1'b1) begin
      n_bad++; $display("FAIL first_run_fetch: got valid=%b want 1", instr_valid_o);
    end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL midfill_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_clears();
    int n;
    step(1'b0, 32'h0, 1'b1, 32'h3010, 32'hDEAD_BEEF);
    step(1'b1, 32'h3010, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    apply_reset(3);
    n = 0;
    while (init_busy_o === 1'b1 && n < 2000) begin
      n++;
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (n != DEPTH) begin
      n_bad++; $display("FAIL clear_fill_length: init_busy high %0d cycles, want %0d", n, DEPTH);
    end
    run_exp = 1'b1;
    step(1'b1, 32'h3010, 1'b0, 32'h0, 32'h0);
    n_cmp++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h0) begin
      n_bad++;
      $display("FAIL cleared_word: got valid=%b instr=%h want 1/00000000", instr_valid_o, instr_o);
    end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL clear_drain: %0d results missing, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_fetch();
    test_collision();
    test_faults();
    test_back_to_back();
    test_midfill_reset();
    test_reset_clears();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation still running at 2ms, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised instruction memory for the MIPS fetch stage.
- Adds a multi-cycle zero-fill after reset, a handshaked program-load port, a registered fetch with a valid flag, and alignment and range fault reporting.
- Sits between the PC/fetch logic and the decode stage.
- The testbench loader or boot logic writes the program through the load port.

Parameters:
- BASE_ADDR, 32'h3000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- AW, $clog2(DEPTH_WORDS), word-index width (derived; do not override).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; restarts zero-fill
- init_busy  out  1  high while zero-fill runs
- fetch_req  in  1  fetch request this cycle
- fetch_ready  out  1  fetch accepted when fetch_req && fetch_ready
- fetch_pc  in  32  byte address to fetch
- instr  out  32  fetched word, valid with instr_valid
- instr_valid  out  1  one-cycle pulse, one cycle after an accepted fetch
- instr_fault  out  2  [0] misaligned (pc[1:0]!=0), [1] out of range; qualified by instr_valid
- load_valid  in  1  load write request
- load_ready  out  1  load accepted when load_valid && load_ready
- load_addr  in  32  byte address of word to write
- load_data  in  32  word to write
- load_err  out  1  one-cycle pulse: an accepted load was dropped because its address faulted

Behaviour:
- Reset
  - Any cycle with reset=1 forces state to CLEAR and clr_idx to 0.
  - Outputs during reset: instr=0, instr_valid=0, instr_fault=0, load_err=0, init_busy=1, fetch_ready=0, load_ready=0.
- State machine: two states, CLEAR and RUN.
- CLEAR
  - Each cycle writes 0 to mem[clr_idx] and increments clr_idx.
  - When clr_idx==DEPTH_WORDS-1 is written, the next state is RUN.
  - Zero-fill takes exactly DEPTH_WORDS cycles after reset deasserts.
  - fetch_ready=0 and load_ready=0; requests are ignored, not queued.
  - Reset asserted mid-fill restarts at index 0.
- RUN
  - init_busy=0, fetch_ready=1, load_ready=1.
  - RUN remains until reset.
- Address decode (fetch and load identically)
  - off = addr - BASE_ADDR, 32-bit modulo.
  - Misaligned = off[1:0]!=0.
  - Out of range = off >= DEPTH_WORDS*4, unsigned. An addr below BASE_ADDR wraps to a large off and so is out of range.
  - Word index = off[AW+1:2].
- Fetch
  - An accepted fetch in cycle N gives registered outputs in cycle N+1: instr_valid=1, instr=mem[idx], instr_fault per decode.
  - If either fault bit is set, instr=32'h00000000 (NOP) and memory is not read.
  - With no accepted fetch, instr_valid=0 and instr holds its last value.
  - Back-to-back fetches give one result per cycle.
- Load
  - An accepted load with no fault writes mem[idx]<=load_data at the clock edge.
  - An accepted load with a fault writes nothing and pulses load_err=1 in cycle N+1.
- Simultaneous load and fetch to the same word in one cycle: read-first. The fetch returns the old contents, and the new data is visible from the next fetch.
- Fetch issued in the last CLEAR cycle: not accepted (fetch_ready=0). The first accepted fetch is in the first RUN cycle.

Decomposition:
- Package imem_pkg:
  - IMEM_BASE_DEFAULT=32'h3000, IMEM_DEPTH_DEFAULT=1024.
  - INSTR_NOP=32'h0.
  - Fault bit indices FAULT_MISALIGN=0, FAULT_RANGE=1.
  - State encoding ST_CLEAR/ST_RUN.
- Sub-module imem_addr_check: combinational; addr in; word index, misaligned and out-of-range out; parametrised by BASE_ADDR and DEPTH_WORDS. Instantiated twice, once for fetch and once for load.

Test Plan:
- Zero-fill: release reset, count cycles -> init_busy high for exactly 1024 cycles; then fetch 0x3000 and 0x3FFC -> instr=0, fault=00.
- Load then fetch: load 0x3004<=0x8C220004, next cycle fetch 0x3004 -> instr_valid one cycle later, instr=0x8C220004, fault=00.
- Read-first collision:
  - Preload 0x3008=0x11111111.
  - Same cycle: load 0x3008<=0x22222222 and fetch 0x3008 -> instr=0x11111111.
  - Refetch -> instr=0x22222222.
- Faults:
  - Fetch 0x3002 -> fault=01, instr=0.
  - Fetch 0x4000 -> fault=10.
  - Fetch 0x2FFC -> fault=10.
  - Fetch 0x0001 -> fault=11.
  - Load 0x4000 -> load_err pulse, and no word in memory changes.
- Mid-fill reset: assert reset at fill cycle 500, release -> init_busy high for a full 1024 cycles; fetch_req held high throughout gets no instr_valid until RUN.
- Reset clears program: load 0x3010<=0xDEADBEEF, reset, wait out the fill, fetch 0x3010 -> instr=0.
